multicycle_scheduler: RTL
=========================

Name: multicycle_scheduler

Overview:
- Shares one multicycle datapath between NREQ requesters.
- Each requester raises a level request with a mode bit. A round-robin arbiter picks one requester, then the block sequences the datapath through load, operate and finish cycles by driving e, s0, s1 and s2.
- On the finish cycle it pulses that requester's done line.
- Sits between the requesting units and the datapath enable and select inputs.

Parameters:
- NREQ, 4, number of requesters (2..8). Pointer width PW = $clog2(NREQ), derived internally and not overridable.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester job request (level)
- mode_in  in  NREQ  per-requester mode; sampled only for the winner at grant
- gnt  out  NREQ  one-hot grant; held from LD through FIN
- e  out  1  datapath register enable
- s0  out  1  datapath select 0
- s1  out  1  datapath select 1
- s2  out  1  datapath select 2
- done  out  NREQ  one-cycle completion pulse to the granted requester
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=IDLE, rr_ptr=0, latched id=0, latched mode=0.
  - gnt=0, done=0, e=s0=s1=s2=0, busy=0.
  - Release is synchronous to the next clock edge. A job in flight is dropped with no done.
- All outputs decode from registered state and latched id/mode only, never combinationally from req.
- Outputs never go X. Unused selects are driven 0.
- FSM states:
  - IDLE: all outputs 0. If req is non-zero, the winner is the first set bit searching from rr_ptr upward, wrapping at NREQ-1→0. On that edge: latch id=winner and mode=mode_in[winner], next state LD. If req=0, stay in IDLE.
  - LD: gnt[id]=1, e=1, s0=0, s1=0, s2=0, busy=1. Next state OP.
  - OP: gnt[id]=1, e=1, s0=1, s1=0, s2=0. Next state FIN.
  - FIN: gnt[id]=1, e=1, s0=1, s1=~mode, s2=mode, done[id]=1. Next state IDLE. On this edge rr_ptr = (id+1) mod NREQ.
- Latency: req sampled high in IDLE at edge k → LD during cycle k+1, done pulse during cycle k+3.
- Throughput: minimum one IDLE cycle between jobs, so one job per 4 cycles.
- Handshake:
  - A requester holds req until it sees done, then drops req in the cycle after done.
  - If req is still high when IDLE samples, it is a new request. It competes normally, and rr_ptr has already moved past it.
- Simultaneous requests: exactly one gnt bit is ever set. Round-robin guarantees each persistent requester is served within NREQ jobs.
- Non-winner requests arriving during LD/OP/FIN are ignored until IDLE. Only req level matters; there is no queueing.
- Changing mode_in after grant has no effect.
- Dropping req[id] mid-job: the job runs to completion and done still pulses (unless MCS_ABORT_EN is defined).
- NREQ not a power of two: the wrap uses an explicit compare to NREQ-1, and the pointer never holds a value ≥ NREQ.

Optional Feature:
- Macro: MCS_ABORT_EN.
- Defined:
  - In LD or OP, if req[id]=0 the FSM goes to IDLE on the next edge.
  - No done pulse, rr_ptr advances to id+1, and e=0 from that next cycle.
  - FIN always completes.
- Not defined: req is ignored after grant, per Behaviour.

Test Plan:
- Reset then req=4'b0100, mode_in[2]=0 → gnt=0100 for 3 cycles. (e,s0,s1,s2) = 1000, 1100, 1110. done=0100 on cycle 3 only, then IDLE.
- req=4'b0010 with mode_in[1]=1 → FIN cycle shows s1=0, s2=1.
- req=4'b1111 held, dropping each bit after its done → grant order 0,1,2,3. rr_ptr returns to 0.
- After serving requester 3, req=4'b1001 → requester 0 wins; next, with req still 1000, requester 3 wins.
- Assert reset low mid-OP → all outputs 0 immediately without a clock. After release with req=0, stays IDLE with no done.
- With MCS_ABORT_EN defined, drop req[id] during LD → e=0 and gnt=0 from the next cycle, done never pulses, next grant search starts at id+1.

Source files
------------

// File: rtl/multicycle_scheduler_if.sv
// Requester/datapath bundle for multicycle_scheduler: job requests in,
// one-hot grant, completion pulses and datapath enable/selects out.
interface multicycle_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] mode_in;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            e;
    logic            s0;
    logic            s1;
    logic            s2;
    logic            busy;

    modport master (
        output req, mode_in,
        input  gnt, done, e, s0, s1, s2, busy
    );

    modport slave (
        input  req, mode_in,
        output gnt, done, e, s0, s1, s2, busy
    );
endinterface

// File: rtl/multicycle_scheduler.sv
// Round-robin scheduler sharing one multicycle datapath (LD -> OP -> FIN).
// Define MCS_ABORT_EN to abandon a job in LD/OP when its requester drops req.
module multicycle_scheduler #(
    parameter int NREQ = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    multicycle_scheduler_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LD, OP, FIN} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   rr_ptr, rr_ptr_next;
    logic [PW-1:0]   id, id_next;
    logic            mode, mode_next;

    logic [PW-1:0]   winner;
    logic            found;
    logic [PW:0]     cand;
    logic [PW-1:0]   id_inc;
    logic [NREQ-1:0] id_onehot;

    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            e, s0, s1, s2, busy;

    // Search from rr_ptr upward; one extra bit keeps the sum from overflowing before the wrap.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ))
                cand = cand - (PW+1)'(NREQ);
            if (!found && bus.req[cand[PW-1:0]]) begin
                found  = 1'b1;
                winner = cand[PW-1:0];
            end
        end
    end

    assign id_inc    = (id == PW'(NREQ-1)) ? '0 : id + 1'b1;
    assign id_onehot = NREQ'(1) << id;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id     <= '0;
            mode   <= 1'b0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            id     <= id_next;
            mode   <= mode_next;
        end
    end

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        id_next     = id;
        mode_next   = mode;
        gnt         = '0;
        done        = '0;
        e           = 1'b0;
        s0          = 1'b0;
        s1          = 1'b0;
        s2          = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = LD;
                    id_next    = winner;
                    mode_next  = bus.mode_in[winner];
                end
            end
            LD: begin
                gnt        = id_onehot;
                e          = 1'b1;
                busy       = 1'b1;
                state_next = OP;
`ifdef MCS_ABORT_EN
                if (!bus.req[id]) begin
                    state_next  = IDLE;
                    rr_ptr_next = id_inc;
                end
`endif
            end
            OP: begin
                gnt        = id_onehot;
                e          = 1'b1;
                s0         = 1'b1;
                busy       = 1'b1;
                state_next = FIN;
`ifdef MCS_ABORT_EN
                if (!bus.req[id]) begin
                    state_next  = IDLE;
                    rr_ptr_next = id_inc;
                end
`endif
            end
            FIN: begin
                gnt         = id_onehot;
                done        = id_onehot;
                e           = 1'b1;
                s0          = 1'b1;
                s1          = ~mode;
                s2          = mode;
                busy        = 1'b1;
                state_next  = IDLE;
                rr_ptr_next = id_inc;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.gnt  = gnt;
    assign bus.done = done;
    assign bus.e    = e;
    assign bus.s0   = s0;
    assign bus.s1   = s1;
    assign bus.s2   = s2;
    assign bus.busy = busy;
endmodule
